delay_share_arb: RTL and testbench

- Shares one fixed-latency Delay line between NR requesters.
- Round-robin arbitration admits at most one beat per cycle into the line. Each beat carries its requester id, which is delayed alongside the data so results return tagged.
- A downstream ready stalls the whole line through CE.
- A flush drops all in-flight beats and scrubs the line.

---
 rtl/delay_share_arb_pkg.sv | 46 ++++
 rtl/delay_share_arb_line.sv | 40 ++++
 rtl/delay_share_arb_rr_arb.sv | 36 +++
 rtl/delay_share_arb.sv | 128 ++++++++++++
 tb/tb_delay_share_arb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_share_arb_pkg.sv
// Shared types and helpers for delay_share_arb: FSM encoding, derived widths
// and the round-robin pick function used by both arbitration builds.
package delay_share_arb_pkg;

    localparam int MAX_NR  = 32;
    localparam int PICK_IW = 5;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

    typedef struct packed {
        logic               any;
        logic [PICK_IW-1:0] idx;
        logic [MAX_NR-1:0]  grant;
    } pick_t;

    function automatic int id_width(input int nr);
        return (nr <= 2) ? 1 : $clog2(nr);
    endfunction

    function automatic int occ_width(input int dn);
        return $clog2(dn + 1);
    endfunction

    // First set bit of vld scanning upward from ptr, wrapping at nr.
    function automatic pick_t rr_pick(input logic [MAX_NR-1:0] vld, input int ptr, input int nr);
        pick_t p;
        int    k;
        p = '0;
        for (int i = 0; i < MAX_NR; i++) begin
            if (i < nr && !p.any) begin
                k = ptr + i;
                if (k >= nr) k = k - nr;
                if (vld[k]) begin
                    p.any      = 1'b1;
                    p.idx      = k[PICK_IW-1:0];
                    p.grant[k] = 1'b1;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/delay_share_arb_line.sv
// Clock-enabled fixed-depth delay line without reset; TP selects between
// discrete per-stage registers ("REG") and an array shifter (SRL/BRAM/AUTO).
module dly_line #(
    parameter int    W  = 8,
    parameter int    D  = 4,
    parameter string TP = "AUTO"
) (
    input  logic         clk,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    generate
        if (TP == "REG") begin : g_reg
            for (genvar gi = 0; gi < D; gi++) begin : g_stage
                logic [W-1:0] q_reg;
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (ce) q_reg <= din;
                    end
                end else begin : g_tail
                    always_ff @(posedge clk) begin
                        if (ce) q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
            assign dout = g_stage[D-1].q_reg;
        end else begin : g_arr
            logic [W-1:0] sr_reg [D];
            always_ff @(posedge clk) begin
                if (ce) begin
                    sr_reg[0] <= din;
                    for (int i = 1; i < D; i++) sr_reg[i] <= sr_reg[i-1];
                end
            end
            assign dout = sr_reg[D-1];
        end
    endgenerate

endmodule

// File: rtl/delay_share_arb_rr_arb.sv
// NR-way round-robin picker; the pointer moves past the winner only when a
// grant is actually issued (en high and some requester valid).
module dly_rr_arb
    import delay_share_arb_pkg::*;
#(
    parameter int NR = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [NR-1:0] vld,
    output logic [NR-1:0] grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr_reg;
    pick_t         pick;
    logic          unused_pick_bits;

    always_comb begin
        pick = rr_pick(MAX_NR'(vld), int'(ptr_reg), NR);
    end

    assign grant            = en ? pick.grant[NR-1:0] : '0;
    assign idx              = pick.idx[IW-1:0];
    assign unused_pick_bits = ^pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (en && pick.any) begin
            ptr_reg <= (idx == IW'(NR-1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/delay_share_arb.sv
// Shares one fixed-latency delay line among NR requesters, tagging each beat
// with its id. Define DLY_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module delay_share_arb
    import delay_share_arb_pkg::*;
#(
    parameter int    SW = 8,
    parameter int    DN = 6,
    parameter int    NR = 4,
    parameter string TP = "AUTO",
    localparam int   IW = id_width(NR),
    localparam int   OW = occ_width(DN)
) (
    input  logic             Ck,
    input  logic             Rst_n,
    input  logic [NR-1:0]    I_Vld,
    output logic [NR-1:0]    I_Rdy,
    input  logic [NR*SW-1:0] I_Data,
    input  logic             I_Flush,
    output logic             O_Vld,
    input  logic             O_Rdy,
    output logic [SW-1:0]    O_Data,
    output logic [IW-1:0]    O_Id,
    output logic [OW-1:0]    Occ,
    output logic             Busy
);
    state_t           state_reg;
    logic [DN-1:0]    vpipe_reg;
    logic [DN-1:0]    vpipe_shift;
    logic [OW-1:0]    occ_reg;
    logic [OW-1:0]    occ_next;
    logic [OW-1:0]    fcnt_reg;
    logic             flushing;
    logic             stall;
    logic             ce;
    logic             arb_en;
    logic             accept;
    logic             out_hs;
    logic [NR-1:0]    grant;
    logic [IW-1:0]    win_idx;
    logic [SW-1:0]    req_data [NR];
    logic [SW+IW-1:0] line_din;
    logic [SW+IW-1:0] line_dout;

    assign flushing = (state_reg == ST_FLUSH);
    assign stall    = vpipe_reg[DN-1] & ~O_Rdy;
    assign ce       = flushing | ~stall;
    // Reset also gates the grant so I_Rdy drops the instant Rst_n falls.
    assign arb_en   = Rst_n & ce & ~flushing & ~I_Flush;
    assign I_Rdy    = grant;
    assign accept   = |(I_Vld & I_Rdy);
    assign O_Vld    = vpipe_reg[DN-1] & ~flushing;
    assign out_hs   = O_Vld & O_Rdy;
    assign occ_next = occ_reg + OW'(accept) - OW'(out_hs);
    assign Occ      = occ_reg;
    assign Busy     = (occ_reg != '0) | flushing;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_req
            assign req_data[gi] = I_Data[gi*SW +: SW];
        end
        if (DN == 1) begin : g_vp1
            assign vpipe_shift = accept;
        end else begin : g_vpn
            assign vpipe_shift = {vpipe_reg[DN-2:0], accept};
        end
    endgenerate

`ifdef DLY_ARB_FIXED_PRIO_EN
    pick_t fixed_pick;
    logic  unused_pick_bits;
    always_comb begin
        fixed_pick = rr_pick(MAX_NR'(I_Vld), 0, NR);
    end
    assign grant            = arb_en ? fixed_pick.grant[NR-1:0] : '0;
    assign win_idx          = fixed_pick.idx[IW-1:0];
    assign unused_pick_bits = ^fixed_pick;
`else
    dly_rr_arb #(
        .NR (NR),
        .IW (IW)
    ) u_arb (
        .clk   (Ck),
        .rst_n (Rst_n),
        .en    (arb_en),
        .vld   (I_Vld),
        .grant (grant),
        .idx   (win_idx)
    );
`endif

    // Zeros are shifted in while flushing so the line ends up scrubbed.
    assign line_din = flushing ? '0 : {win_idx, req_data[win_idx]};

    dly_line #(
        .W  (SW + IW),
        .D  (DN),
        .TP (TP)
    ) u_line (
        .clk  (Ck),
        .ce   (ce),
        .din  (line_din),
        .dout (line_dout)
    );

    assign {O_Id, O_Data} = line_dout;

    always_ff @(posedge Ck or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= ST_IDLE;
            vpipe_reg <= '0;
            occ_reg   <= '0;
            fcnt_reg  <= '0;
        end else if (I_Flush) begin
            state_reg <= ST_FLUSH;
            vpipe_reg <= '0;
            occ_reg   <= '0;
            fcnt_reg  <= OW'(DN-1);
        end else if (flushing) begin
            if (fcnt_reg == '0) state_reg <= ST_IDLE;
            else                fcnt_reg  <= fcnt_reg - 1'b1;
        end else begin
            if (ce) vpipe_reg <= vpipe_shift;
            occ_reg   <= occ_next;
            state_reg <= (occ_next != '0) ? ST_RUN : ST_IDLE;
        end
    end

endmodule

// File: tb/tb_delay_share_arb.sv
// Directed self-checking bench for delay_share_arb (DN=6 main instance plus a
// DN=1 REG instance); output beats are matched in order against a queue.
`timescale 1ns/1ps
module tb_delay_share_arb;

    typedef struct {
        int id;
        int data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [3:0]  vld = '0;
    logic [3:0]  rdy;
    logic [31:0] data = '0;
    logic        flush = 1'b0;
    logic        ovld;
    logic        ordy = 1'b1;
    logic [7:0]  odata;
    logic [1:0]  oid;
    logic [2:0]  occ;
    logic        busy;

    logic [3:0]  vld1 = '0;
    logic [3:0]  rdy1;
    logic [31:0] data1 = '0;
    logic        flush1 = 1'b0;
    logic        ovld1;
    logic        ordy1 = 1'b1;
    logic [7:0]  odata1;
    logic [1:0]  oid1;
    logic [0:0]  occ1;
    logic        busy1;

    int    n_cmp = 0;
    int    n_err = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    delay_share_arb #(.SW(8), .DN(6), .NR(4), .TP("AUTO")) dut (
        .Ck(clk), .Rst_n(rst_n), .I_Vld(vld), .I_Rdy(rdy), .I_Data(data),
        .I_Flush(flush), .O_Vld(ovld), .O_Rdy(ordy), .O_Data(odata),
        .O_Id(oid), .Occ(occ), .Busy(busy)
    );

    delay_share_arb #(.SW(8), .DN(1), .NR(4), .TP("REG")) dut1 (
        .Ck(clk), .Rst_n(rst_n), .I_Vld(vld1), .I_Rdy(rdy1), .I_Data(data1),
        .I_Flush(flush1), .O_Vld(ovld1), .O_Rdy(ordy1), .O_Data(odata1),
        .O_Id(oid1), .Occ(occ1), .Busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_qleft"}, exp_q.size(), 0);
    endtask

    // Called right after the edge that captured a lone beat.
    task automatic lat_check(input string tag, input int id, input int dat);
        for (int k = 1; k <= 6; k++) begin
            check_eq({tag, "_lat_vld"}, ovld, 32'(k == 6));
            if (k < 6) tick();
        end
        check_eq({tag, "_id"}, oid, id);
        check_eq({tag, "_data"}, odata, dat);
        tick();
        check_eq({tag, "_vld_after"}, ovld, 0);
        check_eq({tag, "_occ_after"}, occ, 0);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    // Output monitor: every handshake must match the next expected beat.
    initial begin
        beat_t e;
        logic  have;
        forever begin
            @(negedge clk);
            if (rst_n && ovld && ordy) begin
                have = (exp_q.size() != 0);
                check_eq("out_expected", have, 1);
                if (have) begin
                    e = exp_q.pop_front();
                    check_eq("out_id", oid, e.id);
                    check_eq("out_data", odata, e.data);
                    $display("beat id=%0d data=%02h", oid, odata);
                end
            end
        end
    end

    initial begin
        int exp_k;
        int n;
        int c;
        int occ_max;

        // Reset state
        vld = 4'hF;
        #1;
        check_eq("rst_ovld", ovld, 0);
        check_eq("rst_rdy", rdy, 0);
        check_eq("rst_occ", occ, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst1_occ", occ1, 0);
        vld = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Fairness: all requesters held valid for 8 cycles
        vld = 4'hF;
        data = 32'h13121110;
        for (int i = 0; i < 8; i++) begin
            #1;
`ifdef DLY_ARB_FIXED_PRIO_EN
            exp_k = 0;
`else
            exp_k = i % 4;
`endif
            check_eq("fair_grant", rdy, 32'(1 << exp_k));
            if (i == 6) check_eq("fair_occ", occ, 6);
            exp_q.push_back('{exp_k, 32'h10 + exp_k});
            tick();
        end
        vld = '0;
        drain("fair_drain");

        // Single beat latency
        vld = 4'b0100;
        data = 32'h00A50000;
        #1;
        check_eq("sb_grant", rdy, 4'b0100);
        exp_q.push_back('{2, 32'hA5});
        tick();
        vld = '0;
        check_eq("sb_occ1", occ, 1);
        check_eq("sb_busy1", busy, 1);
        lat_check("sb", 2, 32'hA5);

        // Backpressure: 10 beats, O_Rdy low in cycles 8..10
        n = 0;
        c = 0;
        occ_max = 0;
        while (n < 10 && c < 40) begin
            ordy = !(c >= 8 && c < 11);
            vld = 4'(1 << (n % 4));
            data = '0;
            data[(n % 4)*8 +: 8] = 8'(32'h40 + n);
            #1;
            if (int'(occ) > occ_max) occ_max = int'(occ);
            if (!ordy) begin
                check_eq("bp_stall_rdy", rdy, 0);
                check_eq("bp_stall_vld", ovld, 1);
                check_eq("bp_hold_id", oid, 2);
                check_eq("bp_hold_data", odata, 32'h42);
                check_eq("bp_stall_occ", occ, 6);
            end else begin
                check_eq("bp_grant", rdy, 32'(vld));
                exp_q.push_back('{n % 4, 32'h40 + n});
                n++;
            end
            tick();
            c++;
        end
        check_eq("bp_all_sent", n, 10);
        check_eq("bp_occ_peak", occ_max, 6);
        vld = '0;
        ordy = 1'b1;
        drain("bp_drain");

        // Flush with 4 beats in flight and req 1 valid
        for (int i = 0; i < 4; i++) begin
            vld = 4'b0001;
            data = 32'h60 + i;
            #1;
            check_eq("fl_grant", rdy, 4'b0001);
            tick();
        end
        vld = 4'b0010;
        data = 32'h00007700;
        flush = 1'b1;
        #1;
        check_eq("fl_rdy_suppressed", rdy, 0);
        tick();
        flush = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check_eq("fl_ovld", ovld, 0);
            check_eq("fl_occ", occ, 0);
            check_eq("fl_rdy", rdy, 0);
            check_eq("fl_busy", busy, 1);
            tick();
        end
        #1;
        check_eq("fl_post_grant", rdy, 4'b0010);
        exp_q.push_back('{1, 32'h77});
        tick();
        vld = '0;
        drain("fl_drain");

        // Asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) begin
            vld = 4'b1000;
            data = (32'h80 + i) << 24;
            #1;
            check_eq("rs_grant", rdy, 4'b1000);
            exp_q.push_back('{3, 32'h80 + i});
            tick();
        end
        check_eq("rs_pre_vld", ovld, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rs_ovld", ovld, 0);
        check_eq("rs_rdy", rdy, 0);
        check_eq("rs_occ", occ, 0);
        check_eq("rs_busy", busy, 0);
        exp_q.delete();
        vld = '0;
        tick();
        rst_n = 1'b1;
        vld = 4'b1000;
        data = 32'h99000000;
        #1;
        check_eq("rs_post_grant", rdy, 4'b1000);
        exp_q.push_back('{3, 32'h99});
        tick();
        vld = '0;
        lat_check("rs", 3, 32'h99);

        // DN=1 REG line: back-to-back beats, one out per cycle
        vld1 = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            data1 = 32'hC0 + i;
            #1;
            check_eq("d1_grant", rdy1, 4'b0001);
            if (i > 0) begin
                check_eq("d1_ovld", ovld1, 1);
                check_eq("d1_data", odata1, 32'hC0 + i - 1);
                check_eq("d1_id", oid1, 0);
                check_eq("d1_occ", occ1, 1);
            end
            tick();
        end
        vld1 = '0;
        #1;
        check_eq("d1_last_vld", ovld1, 1);
        check_eq("d1_last_data", odata1, 32'hC4);
        tick();
        check_eq("d1_end_vld", ovld1, 0);
        check_eq("d1_end_occ", occ1, 0);
        check_eq("d1_end_busy", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
